// File: rtl/dmem_access_ctrl.sv
// Data-memory access sequencer: maps word/byte loads and stores onto a word-only
// valid/yumi memory port, doing byte stores as read-modify-write.
module dmem_access_ctrl #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              op_v_i,
  input  logic              is_load_i,
  input  logic              is_store_i,
  input  logic              is_byte_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] store_data_i,
  output logic              op_ready_o,
  output logic              stall_o,
  output logic              done_o,
  output logic [DATA_W-1:0] load_data_o,
  output logic              err_o,
  output logic              mem_v_o,
  output logic              mem_w_o,
  output logic [ADDR_W-3:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic              mem_yumi_i,
  input  logic              mem_resp_v_i,
  input  logic [DATA_W-1:0] mem_rdata_i
);

  typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, WR_REQ, DONE} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q, load_data_q, merged;
  logic              load_q, byte_q, err_q;
  logic [1:0]        lane;
  logic [7:0]        rbyte;
  logic              legal, accept, resp;

  assign legal  = is_load_i ^ is_store_i;
  assign accept = (state == IDLE) && op_v_i && legal;
  assign resp   = (state == RD_WAIT) && mem_resp_v_i;
  assign lane   = addr_q[1:0];
  assign rbyte  = mem_rdata_i[{lane, 3'b000} +: 8];

  // Byte-store merge: read word with the addressed lane replaced by the store byte.
  always_comb begin
    merged = mem_rdata_i;
    merged[{lane, 3'b000} +: 8] = wdata_q[7:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = (is_store_i && !is_byte_i) ? WR_REQ : RD_REQ;
      RD_REQ:  if (mem_yumi_i) state_nxt = RD_WAIT;
      RD_WAIT: if (mem_resp_v_i) state_nxt = load_q ? DONE : WR_REQ;
      WR_REQ:  if (mem_yumi_i) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    op_ready_o = (state == IDLE);
    done_o     = (state == DONE);
    mem_v_o    = (state == RD_REQ) || (state == WR_REQ);
    mem_w_o    = (state == WR_REQ);
    stall_o    = accept || (state == RD_REQ) || (state == RD_WAIT) || (state == WR_REQ);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q      <= '0;
      wdata_q     <= '0;
      load_data_q <= '0;
      load_q      <= 1'b0;
      byte_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      err_q <= (state == IDLE) && op_v_i && is_load_i && is_store_i;
      if (accept) begin
        addr_q  <= addr_i;
        wdata_q <= store_data_i;
        load_q  <= is_load_i;
        byte_q  <= is_byte_i;
      end
      if (resp) begin
        if (!load_q)     wdata_q     <= merged;
        else if (byte_q) load_data_q <= {{(DATA_W-8){1'b0}}, rbyte};
        else             load_data_q <= mem_rdata_i;
      end
    end
  end

  assign err_o       = err_q;
  assign load_data_o = load_data_q;
  assign mem_addr_o  = addr_q[ADDR_W-1:2];
  assign mem_wdata_o = wdata_q;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Directed bench for dmem_access_ctrl: word/byte loads and stores, illegal ops,
// and reset in the middle of a read.
module tb_dmem_access_ctrl;
  logic        clk = 1'b0;
  logic        reset;
  logic        op_v_i, is_load_i, is_store_i, is_byte_i;
  logic [31:0] addr_i, store_data_i;
  logic        op_ready_o, stall_o, done_o, err_o, mem_v_o, mem_w_o;
  logic [31:0] load_data_o, mem_wdata_o;
  logic [29:0] mem_addr_o;
  logic        mem_yumi_i, mem_resp_v_i;
  logic [31:0] mem_rdata_i;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  dmem_access_ctrl #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .reset(reset), .op_v_i(op_v_i), .is_load_i(is_load_i),
    .is_store_i(is_store_i), .is_byte_i(is_byte_i), .addr_i(addr_i),
    .store_data_i(store_data_i), .op_ready_o(op_ready_o), .stall_o(stall_o),
    .done_o(done_o), .load_data_o(load_data_o), .err_o(err_o), .mem_v_o(mem_v_o),
    .mem_w_o(mem_w_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_yumi_i(mem_yumi_i), .mem_resp_v_i(mem_resp_v_i), .mem_rdata_i(mem_rdata_i)
  );

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic drive_op(input logic ld, input logic st, input logic by,
                          input logic [31:0] a, input logic [31:0] d);
    op_v_i = 1'b1; is_load_i = ld; is_store_i = st; is_byte_i = by;
    addr_i = a; store_data_i = d;
    #1;
  endtask

  task automatic clear_op;
    op_v_i = 1'b0; is_load_i = 1'b0; is_store_i = 1'b0; is_byte_i = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1; clear_op(); addr_i = '0; store_data_i = '0;
    mem_yumi_i = 1'b0; mem_resp_v_i = 1'b0; mem_rdata_i = '0;
    #12;
    total++; if ({op_ready_o, stall_o, done_o, err_o, mem_v_o, mem_w_o} !== 6'b100000)
      $display("FAIL reset_ctrl: got %b want 100000", {op_ready_o, stall_o, done_o, err_o, mem_v_o, mem_w_o}); else passed++;
    total++; if ({load_data_o, mem_wdata_o, mem_addr_o} !== 94'd0)
      $display("FAIL reset_data: ld=%h wd=%h ad=%h want 0", load_data_o, mem_wdata_o, mem_addr_o); else passed++;
    @(negedge clk); reset = 1'b0;
    tick();
  endtask

  task automatic test_sw;
    drive_op(1'b0, 1'b1, 1'b0, 32'h100, 32'hDEADBEEF);
    total++; if (stall_o !== 1'b1) $display("FAIL sw_t0_stall: got %b want 1", stall_o); else passed++;
    tick(); clear_op(); mem_yumi_i = 1'b1; #1;
    total++; if ({mem_v_o, mem_w_o, stall_o} !== 3'b111)
      $display("FAIL sw_t1_ctrl: got %b want 111", {mem_v_o, mem_w_o, stall_o}); else passed++;
    total++; if (mem_addr_o !== 30'h40 || mem_wdata_o !== 32'hDEADBEEF)
      $display("FAIL sw_t1_req: addr=%h wdata=%h want 40 deadbeef", mem_addr_o, mem_wdata_o); else passed++;
    tick(); mem_yumi_i = 1'b0;
    total++; if ({done_o, stall_o, mem_v_o, op_ready_o} !== 4'b1000)
      $display("FAIL sw_t2_done: got %b want 1000", {done_o, stall_o, mem_v_o, op_ready_o}); else passed++;
    tick();
    total++; if ({done_o, op_ready_o} !== 2'b01)
      $display("FAIL sw_t3_idle: got %b want 01", {done_o, op_ready_o}); else passed++;
  endtask

  task automatic test_lw_yumi_wait;
    drive_op(1'b1, 1'b0, 1'b0, 32'h104, 32'h0);
    tick(); clear_op();
    for (int i = 0; i < 3; i++) begin
      total++; if ({mem_v_o, mem_w_o, stall_o} !== 3'b101 || mem_addr_o !== 30'h41)
        $display("FAIL lw_hold%0d: v/w/stall=%b addr=%h want 101 41", i, {mem_v_o, mem_w_o, stall_o}, mem_addr_o); else passed++;
      tick();
    end
    mem_yumi_i = 1'b1; #1;
    total++; if (mem_v_o !== 1'b1 || mem_addr_o !== 30'h41)
      $display("FAIL lw_yumi: v=%b addr=%h want 1 41", mem_v_o, mem_addr_o); else passed++;
    tick(); mem_yumi_i = 1'b0;
    total++; if ({mem_v_o, stall_o, done_o} !== 3'b010)
      $display("FAIL lw_wait: got %b want 010", {mem_v_o, stall_o, done_o}); else passed++;
    mem_resp_v_i = 1'b1; mem_rdata_i = 32'h12345678;
    tick(); mem_resp_v_i = 1'b0; mem_rdata_i = '0;
    total++; if (done_o !== 1'b1 || load_data_o !== 32'h12345678)
      $display("FAIL lw_done: done=%b data=%h want 1 12345678", done_o, load_data_o); else passed++;
    tick();
  endtask

  task automatic test_lbu_lanes;
    logic [31:0] exp_tab [4];
    exp_tab[0] = 32'hD4; exp_tab[1] = 32'hC3; exp_tab[2] = 32'hB2; exp_tab[3] = 32'hA1;
    for (int l = 0; l < 4; l++) begin
      drive_op(1'b1, 1'b0, 1'b1, 32'h104 + l, 32'h0);
      tick(); clear_op(); mem_yumi_i = 1'b1;
      tick(); mem_yumi_i = 1'b0; mem_resp_v_i = 1'b1; mem_rdata_i = 32'hA1B2C3D4;
      tick(); mem_resp_v_i = 1'b0; mem_rdata_i = '0;
      total++; if (done_o !== 1'b1 || load_data_o !== exp_tab[l])
        $display("FAIL lbu_lane%0d: done=%b data=%h want 1 %h", l, done_o, load_data_o, exp_tab[l]); else passed++;
      tick();
    end
  endtask

  task automatic test_sb_rmw;
    drive_op(1'b0, 1'b1, 1'b1, 32'h102, 32'hFFFFFF55);
    tick(); clear_op();
    total++; if ({mem_v_o, mem_w_o} !== 2'b10 || mem_addr_o !== 30'h40)
      $display("FAIL sb_rd_req: v/w=%b addr=%h want 10 40", {mem_v_o, mem_w_o}, mem_addr_o); else passed++;
    mem_yumi_i = 1'b1;
    tick(); mem_yumi_i = 1'b0; mem_resp_v_i = 1'b1; mem_rdata_i = 32'h11223344;
    tick(); mem_resp_v_i = 1'b0; mem_rdata_i = '0;
    total++; if ({mem_v_o, mem_w_o} !== 2'b11 || mem_wdata_o !== 32'h11553344 || mem_addr_o !== 30'h40)
      $display("FAIL sb_wr_req: v/w=%b wdata=%h addr=%h want 11 11553344 40", {mem_v_o, mem_w_o}, mem_wdata_o, mem_addr_o); else passed++;
    mem_yumi_i = 1'b1;
    tick(); mem_yumi_i = 1'b0;
    total++; if (done_o !== 1'b1 || load_data_o !== 32'hA1)
      $display("FAIL sb_done: done=%b load_data=%h want 1 a1", done_o, load_data_o); else passed++;
    tick();
  endtask

  task automatic test_illegal;
    drive_op(1'b1, 1'b1, 1'b0, 32'h200, 32'h0);
    total++; if ({stall_o, mem_v_o, op_ready_o} !== 3'b001)
      $display("FAIL ill_t0: got %b want 001", {stall_o, mem_v_o, op_ready_o}); else passed++;
    tick(); clear_op();
    total++; if ({err_o, mem_v_o, op_ready_o} !== 3'b101)
      $display("FAIL ill_err: got %b want 101", {err_o, mem_v_o, op_ready_o}); else passed++;
    tick();
    total++; if (err_o !== 1'b0) $display("FAIL ill_err_pulse: got %b want 0", err_o); else passed++;
    drive_op(1'b0, 1'b0, 1'b0, 32'h200, 32'h0);
    total++; if (stall_o !== 1'b0) $display("FAIL nop_stall: got %b want 0", stall_o); else passed++;
    tick(); clear_op();
    total++; if ({err_o, mem_v_o, op_ready_o} !== 3'b001)
      $display("FAIL nop_idle: got %b want 001", {err_o, mem_v_o, op_ready_o}); else passed++;
  endtask

  task automatic test_reset_mid;
    drive_op(1'b1, 1'b0, 1'b0, 32'h108, 32'h0);
    tick(); clear_op(); mem_yumi_i = 1'b1;
    tick(); mem_yumi_i = 1'b0;
    reset = 1'b1; #1;
    total++; if ({op_ready_o, stall_o, mem_v_o, done_o} !== 4'b1000 || load_data_o !== 32'h0)
      $display("FAIL rst_mid: ctrl=%b ld=%h want 1000 0", {op_ready_o, stall_o, mem_v_o, done_o}, load_data_o); else passed++;
    tick(); reset = 1'b0;
    tick(); mem_resp_v_i = 1'b1; mem_rdata_i = 32'hFFFFFFFF;
    tick(); mem_resp_v_i = 1'b0; mem_rdata_i = '0;
    total++; if ({op_ready_o, done_o, mem_v_o, stall_o} !== 4'b1000 || load_data_o !== 32'h0)
      $display("FAIL rst_stale_resp: ctrl=%b ld=%h want 1000 0", {op_ready_o, done_o, mem_v_o, stall_o}, load_data_o); else passed++;
    tick();
    total++; if ({op_ready_o, done_o, mem_v_o} !== 3'b100)
      $display("FAIL rst_settle: got %b want 100", {op_ready_o, done_o, mem_v_o}); else passed++;
  endtask

  initial begin
    test_reset();
    test_sw();
    test_lw_yumi_wait();
    test_lbu_lanes();
    test_sb_rmw();
    test_illegal();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/dmem_access_ctrl.md
Name: dmem_access_ctrl

Overview:
- Sequences every data-memory operation flagged by the core's decode stage (word/byte loads and stores) onto a word-only data memory port with a valid/yumi request handshake and a separate read-response strobe.
- Byte stores are done as read-modify-write, because the memory has no byte mask.
- Byte loads are extracted from the addressed lane and zero-extended.
- Sits between the core's execute/memory stage and the data memory; asserts stall_o to freeze the pipeline while an access is in flight.

Parameters:
- ADDR_W, 32, byte-address width from the core; memory word address is ADDR_W-2 bits.
- DATA_W, 32, data word width. Fixed at 32; byte-lane logic assumes 4 lanes.

Ports:
- clk  input  1  core clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- op_v_i  input  1  core presents a decoded memory op this cycle.
- is_load_i  input  1  op is a load (LW/LBU).
- is_store_i  input  1  op is a store (SW/SB).
- is_byte_i  input  1  op is byte-sized (LBU/SB); otherwise word.
- addr_i  input  ADDR_W  byte address; little-endian; lane = addr_i[1:0].
- store_data_i  input  DATA_W  store data; SB uses bits [7:0].
- op_ready_o  output  1  controller is idle and can accept an op.
- stall_o  output  1  core must hold its memory stage.
- done_o  output  1  one-cycle pulse when the op completes.
- load_data_o  output  DATA_W  result of the last completed load.
- err_o  output  1  one-cycle pulse when an illegal op is rejected.
- mem_v_o  output  1  memory request valid.
- mem_w_o  output  1  request is a write (1) or a read (0).
- mem_addr_o  output  ADDR_W-2  word address, taken from addr[ADDR_W-1:2].
- mem_wdata_o  output  DATA_W  write data.
- mem_yumi_i  input  1  memory accepts the request this cycle.
- mem_resp_v_i  input  1  read data valid.
- mem_rdata_i  input  DATA_W  read data.

Behaviour:
- States: IDLE, RD_REQ, RD_WAIT, WR_REQ, DONE.
- Reset (async) forces:
  - state to IDLE;
  - all captured registers (address, wdata, flags, load_data) to 0;
  - every output to 0 except op_ready_o=1.
- op_ready_o = (state==IDLE).
- Accepting an op in IDLE:
  - An op is accepted when op_v_i=1.
  - If is_load_i=is_store_i=1: the op is not accepted, err_o pulses the next cycle, state stays IDLE.
  - If is_load_i=is_store_i=0: ignored silently.
  - On a legal accept, capture addr, store_data, load/store/byte flags.
- IDLE transitions on legal accept:
  - SW goes to WR_REQ with mem_wdata = store_data.
  - LW, LBU and SB go to RD_REQ.
- RD_REQ: mem_v_o=1, mem_w_o=0. Go to RD_WAIT on mem_yumi_i; otherwise hold.
- RD_WAIT: mem_v_o=0. On mem_resp_v_i:
  - Byte store: wdata = rdata with lane addr[1:0] replaced by store_data[7:0]; go to WR_REQ.
  - LW: load_data = rdata; go to DONE.
  - LBU: load_data = {24'b0, rdata lane byte}; go to DONE.
- WR_REQ: mem_v_o=1, mem_w_o=1. Go to DONE on mem_yumi_i. Writes produce no response.
- DONE: done_o=1 for one cycle; go to IDLE. op_ready_o=0, so no accept is possible in this cycle.
- stall_o = (state==IDLE & op_v_i & legal op) | state in {RD_REQ, RD_WAIT, WR_REQ}. It is combinational so the core freezes in the accept cycle; it is low in DONE.
- mem_v_o, mem_w_o, mem_addr_o and mem_wdata_o stay stable from assertion until the yumi cycle. mem_v_o never drops before yumi.
- mem_resp_v_i outside RD_WAIT is ignored. That includes a stale response after a reset.
- load_data_o holds its value until the next load completes. Stores never change it.
- Latency with immediate yumi and a next-cycle response:
  - SW: accept t0, done_o at t2.
  - LW/LBU: done_o at t3.
  - SB: done_o at t4.
- Reset mid-operation abandons the transaction immediately; no memory request is reissued.

Test Plan:
- SW addr=0x100, data=0xDEADBEEF, yumi immediate -> mem_v_o=1, w=1, mem_addr_o=0x40, wdata=0xDEADBEEF at t1; done_o at t2; stall_o high t0-t1.
- LW addr=0x104, yumi held low 3 cycles, rdata=0x12345678 -> mem_v_o and addr stable through the stall; load_data_o=0x12345678; done_o one cycle after the response.
- LBU addr=0x107, rdata=0xA1B2C3D4 -> load_data_o=0x000000A1. Repeat for lanes 0,1,2 -> 0xD4, 0xC3, 0xB2.
- SB addr=0x102, data=0x55, rdata=0x11223344 -> read then write with wdata=0x11553344; done_o at t4; load_data_o unchanged.
- op_v_i with is_load_i=is_store_i=1 -> no mem_v_o, err_o pulse, op_ready_o stays 1. op_v_i with neither flag set -> no activity, no err_o.
- Reset asserted in RD_WAIT, then mem_resp_v_i pulses after reset release -> IDLE, all outputs 0, response ignored, load_data_o=0.
